// File: rtl/hit_fifo_if.sv
// hit_fifo_if: bundles the hit FIFO write/read/control handshake and status.
// master = producer/consumer side driving requests; slave = FIFO side.
// Fields s/q/l are subject offset, query offset and hit length.
interface hit_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] in_s;
    logic [DATA_W-1:0] in_q;
    logic [DATA_W-1:0] in_l;
    logic              rd_en;
    logic              clr_err;
    logic [DATA_W-1:0] out_s;
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] out_l;
    logic              out_valid;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, wr_en, in_s, in_q, in_l, rd_en, clr_err,
        input  out_s, out_q, out_l, out_valid, empty, full, almost_full,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, in_s, in_q, in_l, rd_en, clr_err,
        output out_s, out_q, out_l, out_valid, empty, full, almost_full,
               count, overflow, underflow
    );
endinterface

// File: rtl/hit_fifo.sv
// hit_fifo: buffers (s, q, l) hit triples between seed extension and hit collector.
// Latency: write visible after 1 edge; pop data + out_valid registered, 1 cycle.
// Backpressure: full/almost_full from registered count; write on full only with a pop.
// Ports: clk, rst (sync, active high), bus (hit_fifo_if.slave) carrying
// flush/wr/rd/clr_err requests, registered read data and status/error flags.
module hit_fifo #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int AFULL_LVL = (1 << ADDR_W) - 4,
    parameter int DROP_ZERO = 1
) (
    input  logic      clk,
    input  logic      rst,
    hit_fifo_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam int ENT_W = 3 * DATA_W;

    logic [ENT_W-1:0]  mem [DEPTH];

    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ENT_W-1:0]  out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic empty, full, filt_ok, rd_ok, wr_ok;

    // Flags decode only the registered count.
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign filt_ok = !((DROP_ZERO != 0) && (bus.in_l == '0));
    assign rd_ok   = bus.rd_en && !empty;
    // A full FIFO frees its slot in the same edge if a pop is accepted.
    assign wr_ok   = bus.wr_en && filt_ok && (!full || rd_ok);

    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_d       = '0;
        out_valid_d = 1'b0;
        ovf_d       = ovf_q;
        unf_d       = unf_q;

        if (bus.clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end

        if (bus.flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (rd_ok) begin
                rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
                out_d       = mem[rd_ptr_q];
                out_valid_d = 1'b1;
            end
            if (wr_ok && !rd_ok)      count_d = count_q + CNT_W'(1);
            else if (rd_ok && !wr_ok) count_d = count_q - CNT_W'(1);
            // Set beats clear when both happen in the same cycle.
            if (bus.wr_en && filt_ok && full && !rd_ok) ovf_d = 1'b1;
            if (bus.rd_en && empty)                     unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // Storage is not reset; a write in a reset or flush cycle is discarded.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush && wr_ok) begin
            mem[wr_ptr_q] <= {bus.in_s, bus.in_q, bus.in_l};
        end
    end

    assign bus.out_s       = out_q[ENT_W-1 -: DATA_W];
    assign bus.out_q       = out_q[2*DATA_W-1 -: DATA_W];
    assign bus.out_l       = out_q[DATA_W-1:0];
    assign bus.out_valid   = out_valid_q;
    assign bus.empty       = empty;
    assign bus.full        = full;
    assign bus.almost_full = (count_q >= CNT_W'(AFULL_LVL));
    assign bus.count       = count_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;
endmodule

// File: tb/tb_hit_fifo.sv
module tb_hit_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    hit_fifo_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    hit_fifo #(.DATA_W(8), .ADDR_W(3), .AFULL_LVL(4), .DROP_ZERO(1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // One clock with the given inputs, sampled 1 time unit after the edge.
    task automatic step(input logic w, input logic [7:0] s, input logic [7:0] q,
                        input logic [7:0] l, input logic r,
                        input logic f = 1'b0, input logic c = 1'b0);
        bus.wr_en = w; bus.in_s = s; bus.in_q = q; bus.in_l = l;
        bus.rd_en = r; bus.flush = f; bus.clr_err = c;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
        bus.in_s = '0; bus.in_q = '0; bus.in_l = '0;
    endtask

    function automatic logic [23:0] trip();
        return {bus.out_s, bus.out_q, bus.out_l};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", bus.count); end
        total++; if ({bus.empty, bus.full, bus.almost_full} !== 3'b100) begin bad++; $display("FAIL rst_flags got=%b want=100", {bus.empty, bus.full, bus.almost_full}); end
        total++; if ({bus.out_valid, trip()} !== 25'd0) begin bad++; $display("FAIL rst_out got=%h want=0", {bus.out_valid, trip()}); end
        total++; if ({bus.overflow, bus.underflow} !== 2'b00) begin bad++; $display("FAIL rst_err got=%b want=00", {bus.overflow, bus.underflow}); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [23:0] exp [3];
        exp[0] = 24'h010203; exp[1] = 24'h040506; exp[2] = 24'h070809;
        for (int i = 0; i < 3; i++) begin
            step(1, exp[i][23:16], exp[i][15:8], exp[i][7:0], 0);
            total++; if (bus.count !== 4'(i + 1)) begin bad++; $display("FAIL basic_wr_count got=%0d want=%0d", bus.count, i + 1); end
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1);
            total++; if ({bus.out_valid, trip()} !== {1'b1, exp[i]}) begin bad++; $display("FAIL basic_rd got=%h want=%h", {bus.out_valid, trip()}, {1'b1, exp[i]}); end
            total++; if (bus.count !== 4'(2 - i)) begin bad++; $display("FAIL basic_rd_count got=%0d want=%0d", bus.count, 2 - i); end
        end
        step(0, 0, 0, 0, 0);
        total++; if ({bus.out_valid, trip()} !== 25'd0) begin bad++; $display("FAIL basic_idle_out got=%h want=0", {bus.out_valid, trip()}); end
        total++; if ({bus.empty, bus.underflow} !== 2'b10) begin bad++; $display("FAIL basic_end got=%b want=10", {bus.empty, bus.underflow}); end
    endtask

    task automatic test_drop_zero();
        step(1, 5, 5, 0, 0);
        total++; if ({bus.count, bus.overflow} !== 5'b00000) begin bad++; $display("FAIL drop_zero got=%b want=00000", {bus.count, bus.overflow}); end
        step(1, 5, 5, 1, 0);
        total++; if (bus.count !== 4'd1) begin bad++; $display("FAIL drop_nonzero got=%0d want=1", bus.count); end
        step(0, 0, 0, 0, 1);
        total++; if ({bus.out_valid, trip()} !== {1'b1, 24'h050501}) begin bad++; $display("FAIL drop_rd got=%h want=1050501", {bus.out_valid, trip()}); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            step(1, 8'(10 + i), 8'(20 + i), 8'(30 + i), 0);
            total++; if ({bus.almost_full, bus.full} !== {(i + 1) >= 4, (i + 1) == 8}) begin bad++; $display("FAIL full_flags n=%0d got=%b want=%b", i + 1, {bus.almost_full, bus.full}, {(i + 1) >= 4, (i + 1) == 8}); end
        end
        step(1, 99, 99, 99, 0);
        total++; if ({bus.count, bus.overflow, bus.out_valid} !== {4'd8, 2'b10}) begin bad++; $display("FAIL full_reject got=%b want=100010", {bus.count, bus.overflow, bus.out_valid}); end
        step(0, 0, 0, 0, 0, 0, 1);
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL full_clr got=%b want=0", bus.overflow); end
        step(1, 50, 51, 52, 1);
        total++; if ({bus.out_valid, trip()} !== {1'b1, 8'd10, 8'd20, 8'd30}) begin bad++; $display("FAIL full_rw_out got=%h want=10a141e", {bus.out_valid, trip()}); end
        total++; if ({bus.count, bus.full, bus.overflow} !== {4'd8, 2'b10}) begin bad++; $display("FAIL full_rw_cnt got=%b want=100010", {bus.count, bus.full, bus.overflow}); end
        for (int i = 1; i < 9; i++) begin
            step(0, 0, 0, 0, 1);
            total++;
            if (trip() !== ((i < 8) ? {8'(10 + i), 8'(20 + i), 8'(30 + i)} : 24'h323334)) begin
                bad++; $display("FAIL full_drain i=%0d got=%h", i, trip());
            end
        end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL full_drain_empty got=%b want=1", bus.empty); end
    endtask

    task automatic test_stream();
        logic [23:0] exp_q [$];
        logic [23:0] e;
        for (int i = 0; i < 23; i++) begin
            logic w, r;
            w = (i < 20);
            r = (i >= 3);
            if (r) e = exp_q.pop_front();
            if (w) exp_q.push_back({8'(i), 8'(i + 100), 8'(i + 1)});
            step(w, 8'(i), 8'(i + 100), 8'(i + 1), r);
            if (r) begin
                total++; if ({bus.out_valid, trip()} !== {1'b1, e}) begin bad++; $display("FAIL stream i=%0d got=%h want=%h", i, {bus.out_valid, trip()}, {1'b1, e}); end
            end
            if (i >= 2 && i < 20) begin
                total++; if (bus.count !== 4'd3) begin bad++; $display("FAIL stream_cnt i=%0d got=%0d want=3", i, bus.count); end
            end
        end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL stream_empty got=%b want=1", bus.empty); end
    endtask

    task automatic test_underflow();
        step(1, 1, 1, 1, 1);
        total++; if ({bus.out_valid, bus.underflow, bus.count} !== {2'b01, 4'd1}) begin bad++; $display("FAIL unf_set got=%b want=010001", {bus.out_valid, bus.underflow, bus.count}); end
        step(0, 0, 0, 0, 0, 0, 1);
        total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL unf_clr got=%b want=0", bus.underflow); end
        step(0, 0, 0, 0, 1);
        total++; if ({bus.out_valid, trip()} !== {1'b1, 24'h010101}) begin bad++; $display("FAIL unf_rd got=%h want=1010101", {bus.out_valid, trip()}); end
        step(0, 0, 0, 0, 1, 0, 1);
        total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL unf_set_wins got=%b want=1", bus.underflow); end
        step(0, 0, 0, 0, 0, 0, 1);
        total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL unf_clr2 got=%b want=0", bus.underflow); end
    endtask

    task automatic test_flush();
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 8'(40 + i), 8'(40 + i), 8'(40 + i), 0);
        total++; if (bus.count !== 4'd5) begin bad++; $display("FAIL flush_pre got=%0d want=5", bus.count); end
        step(1, 9, 9, 9, 1, 1);
        total++; if ({bus.count, bus.out_valid, bus.empty} !== {4'd0, 2'b01}) begin bad++; $display("FAIL flush_state got=%b want=000001", {bus.count, bus.out_valid, bus.empty}); end
        total++; if ({bus.overflow, bus.underflow} !== 2'b01) begin bad++; $display("FAIL flush_err got=%b want=01", {bus.overflow, bus.underflow}); end
        step(1, 77, 78, 79, 0);
        total++; if (bus.count !== 4'd1) begin bad++; $display("FAIL flush_new_cnt got=%0d want=1", bus.count); end
        step(0, 0, 0, 0, 1);
        total++; if ({bus.out_valid, trip(), bus.empty} !== {1'b1, 24'h4d4e4f, 1'b1}) begin bad++; $display("FAIL flush_new_rd got=%h", {bus.out_valid, trip(), bus.empty}); end
        // Reset mid-stream with a concurrent write keeps nothing.
        step(1, 3, 3, 3, 0);
        rst = 1'b1;
        step(1, 4, 4, 4, 0);
        rst = 1'b0;
        total++; if ({bus.count, bus.empty, bus.underflow} !== {4'd0, 2'b10}) begin bad++; $display("FAIL midrst got=%b want=000010", {bus.count, bus.empty, bus.underflow}); end
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
        bus.in_s = '0; bus.in_q = '0; bus.in_l = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_drop_zero();
        test_full();
        test_stream();
        test_underflow();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hit_fifo.md
# hit_fifo

Parametrised successor to the single-width hit FIFO in the BLAST pipeline. It buffers (subject offset, query offset, hit length) triples between the seed-extension stage and the hit collector. Compared with the earlier block, it adds:
- configurable field width and depth;
- a correct full flag at full depth;
- read-and-write on a full FIFO;
- a registered output-valid strobe, almost-full back-pressure, flush, and sticky overflow/underflow error flags.

## Interface
Parameters:
- DATA_W, 8, width of each field (s, q, l)
- ADDR_W, 8, pointer width; DEPTH = 2^ADDR_W entries
- AFULL_LVL, 2^ADDR_W-4, almost_full asserts when count >= AFULL_LVL
- DROP_ZERO, 1, when 1 writes with in_l == 0 are silently discarded

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous clear of contents (not of error flags)
- wr_en  in  1  write request
- in_s, in_q, in_l  in  DATA_W each  write data fields
- rd_en  in  1  read request
- out_s, out_q, out_l  out  DATA_W each  read data, registered
- out_valid  out  1  out_* carry a popped entry this cycle
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AFULL_LVL
- count  out  ADDR_W+1  number of stored entries, 0..DEPTH
- overflow  out  1  sticky: write lost due to full
- underflow  out  1  sticky: read requested while empty
- clr_err  in  1  clears overflow/underflow

## Operation
- Reset values: count=0, pointers=0, empty=1, full=0, almost_full=0, out_*=0, out_valid=0, overflow=0, underflow=0. Memory contents are not reset.
- Read acceptance: rd_ok = rd_en && !empty.
- Write acceptance: wr_ok = wr_en && !(DROP_ZERO && in_l==0) && (!full || rd_ok). A write on a full FIFO is accepted only with a simultaneous accepted read.
- Read on empty with a simultaneous write is rejected. Data is never bypassed.
- Count update:
  - +1 when wr_ok && !rd_ok
  - -1 when rd_ok && !wr_ok
  - unchanged otherwise
- Pointers are ADDR_W bits wide. wr_ptr increments on wr_ok; rd_ptr increments on rd_ok. Both wrap modulo DEPTH with no special case.
- Flag sources: empty, full and almost_full decode the registered count only; there is no combinational path from wr_en/rd_en.
- Flush: count and pointers go to 0 and out_valid to 0. The flush cycle ignores wr_en/rd_en. Precedence is rst > flush > normal operation.
- overflow: set when wr_en && in_l-filter passes && full && !rd_ok.
- underflow: set when rd_en && empty.
- clr_err clears both error flags. If a set condition and clr_err coincide, set wins.
- Dropped zero-length writes are not errors and do not touch pointers.

## Timing
- Write latency: an entry written at edge N is readable (empty=0) from edge N onward, so the earliest pop is at edge N+1.
- Read latency: on rd_ok at edge N, out_* hold mem[rd_ptr] and out_valid=1 after edge N, for exactly one cycle.
- When there is no rd_ok, out_* = 0 and out_valid = 0 after the edge.
- Back-to-back reads every cycle produce one valid entry per cycle until empty.
- Full throughput: with simultaneous wr_ok and rd_ok every cycle, count is constant, including at count == DEPTH and count == 1.
- A reset or flush asserted mid-stream takes effect at that edge. No entry written in that cycle is retained.

## Test plan
- Reset, then write 3 triples (1,2,3),(4,5,6),(7,8,9), then read 3 → out_valid pulses once per read with triples in order; count goes 3→0; empty=1; underflow=0.
- DROP_ZERO=1, write (5,5,0) → count stays 0 and overflow stays 0. Then write (5,5,1) → count=1.
- ADDR_W=3: write 8 entries → full=1 at count=8; almost_full from count=4.
  - 9th write alone → rejected, overflow=1.
  - 9th write with simultaneous read → accepted, count stays 8, oldest entry out.
- ADDR_W=3: write/read 20 entries in a streaming pattern across pointer wrap → output sequence matches the input sequence exactly.
- rd_en on empty with simultaneous wr_en → out_valid=0, underflow=1, count=1. Then clr_err → underflow=0. clr_err held during a new underflow → flag stays 1.
- With 5 entries stored, assert flush together with wr_en and rd_en → count=0, out_valid=0, error flags unchanged. Next write/read returns only new data.
